// File: rtl/mycpu_mem_access_if.sv
// SRAM-like data bus between the MEM-stage access controller (master) and data memory (slave).
interface mycpu_mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic [31:0]       data_rdata;
    logic              data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );
endinterface

// File: rtl/mycpu_mem_access.sv
// MEM-stage data-access controller: issues one bus access per captured op, then aligns,
// extends or merges load data and hands the result to WB under valid/ready.
module mycpu_mem_access #(
    parameter int ADDR_W = 32,
    parameter int DEST_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_load,
    input  logic                in_is_store,
    input  logic [2:0]          in_ld_mode,
    input  logic [1:0]          in_st_mode,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [3:0]          in_wen,
    input  logic [31:0]         in_wdata,
    input  logic [31:0]         in_rt_old,
    input  logic [31:0]         in_pass_data,
    input  logic [DEST_W-1:0]   in_dest,
    mycpu_mem_access_if.master  bus,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic [DEST_W-1:0]   out_dest,
    output logic                out_wen
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q,     state_d;
    logic                is_load_q,   is_load_d;
    logic                is_store_q,  is_store_d;
    logic [2:0]          ld_mode_q,   ld_mode_d;
    logic [1:0]          st_mode_q,   st_mode_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [3:0]          wen_q,       wen_d;
    logic [31:0]         wdata_q,     wdata_d;
    logic [31:0]         rt_old_q,    rt_old_d;
    logic [31:0]         out_data_q,  out_data_d;
    logic [DEST_W-1:0]   out_dest_q,  out_dest_d;
    logic                out_wen_q,   out_wen_d;

    logic [1:0]  a;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] m, r, load_result;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;

    assign a        = addr_q[1:0];
    assign m        = bus.data_rdata;
    assign r        = rt_old_q;
    assign ld_byte  = m[{a, 3'b000} +: 8];
    assign ld_half  = m[{a[1], 4'b0000} +: 16];
    assign st_wstrb = wen_q << a;
    assign st_wdata = wdata_q << {a, 3'b000};

    always_comb begin
        load_result = m;
        case (ld_mode_q)
            3'd0: load_result = {{24{ld_byte[7]}}, ld_byte};
            3'd1: load_result = {24'h0, ld_byte};
            3'd2: load_result = {{16{ld_half[15]}}, ld_half};
            3'd3: load_result = {16'h0, ld_half};
            3'd5: begin
                case (a)
                    2'd0:    load_result = {m[7:0],  r[23:0]};
                    2'd1:    load_result = {m[15:0], r[15:0]};
                    2'd2:    load_result = {m[23:0], r[7:0]};
                    default: load_result = m;
                endcase
            end
            3'd6: begin
                case (a)
                    2'd0:    load_result = m;
                    2'd1:    load_result = {r[31:24], m[31:8]};
                    2'd2:    load_result = {r[31:16], m[31:16]};
                    default: load_result = {r[31:8],  m[31:24]};
                endcase
            end
            default: load_result = m;
        endcase
    end

    // Bus fields come straight from the captured op, so they stay stable through REQ.
    always_comb begin
        bus.data_req   = (state_q == REQ);
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = '0;
        bus.data_wstrb = 4'h0;
        bus.data_wdata = 32'h0;
        if (is_load_q) begin
            case (ld_mode_q)
                3'd0, 3'd1: begin bus.data_size = 2'd0; bus.data_addr = addr_q; end
                3'd2, 3'd3: begin bus.data_size = 2'd1; bus.data_addr = addr_q; end
                default:    begin bus.data_size = 2'd2; bus.data_addr = {addr_q[ADDR_W-1:2], 2'b00}; end
            endcase
        end else if (is_store_q) begin
            bus.data_wr = 1'b1;
            if (st_mode_q == 2'd0 || st_mode_q == 2'd1) begin
                bus.data_size  = st_mode_q;
                bus.data_addr  = addr_q;
                bus.data_wstrb = st_wstrb;
                bus.data_wdata = st_wdata;
            end else begin
                bus.data_size  = 2'd2;
                bus.data_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.data_wstrb = wen_q;
                bus.data_wdata = wdata_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        ld_mode_d  = ld_mode_q;
        st_mode_d  = st_mode_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        rt_old_d   = rt_old_q;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        out_wen_d  = out_wen_q;
        in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);

        case (state_q)
            REQ:  if (bus.data_addr_ok) state_d = WAIT;
            WAIT: begin
                if (bus.data_data_ok) begin
                    out_data_d = is_load_q ? load_result : 32'h0;
                    state_d    = DONE;
                end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A load flag wins if both are set, so an op is never treated as a store and a load.
        if (in_valid && in_ready) begin
            is_load_d  = in_is_load;
            is_store_d = in_is_store && !in_is_load;
            ld_mode_d  = in_ld_mode;
            st_mode_d  = in_st_mode;
            addr_d     = in_addr;
            wen_d      = in_wen;
            wdata_d    = in_wdata;
            rt_old_d   = in_rt_old;
            out_dest_d = in_dest;
            out_wen_d  = !(in_is_store && !in_is_load);
            out_data_d = (in_is_load || in_is_store) ? 32'h0 : in_pass_data;
            state_d    = (in_is_load || in_is_store) ? REQ : DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            ld_mode_q  <= 3'd0;
            st_mode_q  <= 2'd0;
            addr_q     <= '0;
            wen_q      <= 4'h0;
            wdata_q    <= 32'h0;
            rt_old_q   <= 32'h0;
            out_data_q <= 32'h0;
            out_dest_q <= '0;
            out_wen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            ld_mode_q  <= ld_mode_d;
            st_mode_q  <= st_mode_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            rt_old_q   <= rt_old_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
            out_wen_q  <= out_wen_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_dest  = out_dest_q;
    assign out_wen   = out_wen_q;
endmodule

// File: tb/tb_mycpu_mem_access.sv
// Bench for mycpu_mem_access: directed cases plus random ops against a behavioural model,
// with the bench acting as data memory and WB stage.
module tb_mycpu_mem_access;
    localparam int ADDR_W = 32;
    localparam int DEST_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]        in_ld_mode;
    logic [1:0]        in_st_mode;
    logic [ADDR_W-1:0] in_addr;
    logic [3:0]        in_wen;
    logic [31:0]       in_wdata, in_rt_old, in_pass_data;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid, out_ready, out_wen;
    logic [31:0]       out_data;
    logic [DEST_W-1:0] out_dest;

    mycpu_mem_access_if #(.ADDR_W(ADDR_W)) bus_if ();

    mycpu_mem_access #(.ADDR_W(ADDR_W), .DEST_W(DEST_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_ld_mode(in_ld_mode), .in_st_mode(in_st_mode),
        .in_addr(in_addr), .in_wen(in_wen), .in_wdata(in_wdata),
        .in_rt_old(in_rt_old), .in_pass_data(in_pass_data), .in_dest(in_dest),
        .bus(bus_if),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest), .out_wen(out_wen)
    );

    int tests = 0;
    int fails = 0;

    // Expected op and bus image for the op in flight.
    bit          e_mem, e_ld;
    int          e_ldm;
    logic [31:0] e_addr, e_rt, e_dest;
    logic [31:0] exp_wr, exp_size, exp_baddr, exp_wstrb, exp_bwd, exp_out, exp_owen;
    logic [31:0] seen_wstrb, seen_wdata, seen_size;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input int mode, input int a,
                                               input logic [31:0] m, input logic [31:0] r);
        logic [31:0] b, h;
        int sh;
        b = (m >> (8 * a)) & 32'hFF;
        h = (m >> (16 * (a / 2))) & 32'hFFFF;
        case (mode)
            0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            1: return b;
            2: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3: return h;
            5: begin
                sh = 8 * (3 - a);
                return (m << sh) | (r & ((32'd1 << sh) - 32'd1));
            end
            6: begin
                sh = 8 * a;
                return (m >> sh) | (r & ~(32'hFFFF_FFFF >> sh));
            end
            default: return m;
        endcase
    endfunction

    task automatic set_op(input bit ld, input bit st, input int ldm, input int stm,
                          input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd,
                          input logic [31:0] rt, input logic [31:0] pass, input int dest);
        int a;
        bit e_st;
        a      = int'(addr[1:0]);
        e_mem  = ld || st;
        e_ld   = ld;
        e_st   = st && !ld;
        e_ldm  = ldm;
        e_addr = addr;
        e_rt   = rt;
        e_dest = 32'(dest);
        exp_owen = e_st ? 32'd0 : 32'd1;
        exp_out  = e_mem ? 32'd0 : pass;
        exp_wr = 0; exp_size = 0; exp_baddr = 0; exp_wstrb = 0; exp_bwd = 0;
        if (e_ld) begin
            exp_size  = (ldm < 2) ? 32'd0 : (ldm < 4) ? 32'd1 : 32'd2;
            exp_baddr = (exp_size == 2) ? (addr & ~32'h3) : addr;
        end else if (e_st) begin
            exp_wr    = 1;
            exp_size  = (stm < 2) ? 32'(stm) : 32'd2;
            exp_baddr = (exp_size == 2) ? (addr & ~32'h3) : addr;
            exp_wstrb = (stm < 2) ? ((32'(wen) << a) & 32'hF) : 32'(wen);
            exp_bwd   = (stm < 2) ? (wd << (8 * a)) : wd;
        end
        in_is_load = ld; in_is_store = st;
        in_ld_mode = 3'(ldm); in_st_mode = 2'(stm);
        in_addr = addr; in_wen = wen; in_wdata = wd; in_rt_old = rt;
        in_pass_data = pass; in_dest = DEST_W'(dest);
        in_valid = 1'b1;
        #1;
        chk("in_ready_capture", 32'(in_ready), 32'd1);
    endtask

    task automatic serve_bus(input int adly, input int ddly, input logic [31:0] rd, input bit spur);
        for (int i = 0; i <= adly; i++) begin
            bus_if.data_data_ok = spur && (i < adly);
            bus_if.data_rdata   = $urandom;
            chk("req_high",    32'(bus_if.data_req),  32'd1);
            chk("bus_wr",      32'(bus_if.data_wr),   exp_wr);
            chk("bus_size",    32'(bus_if.data_size), exp_size);
            chk("bus_addr",    bus_if.data_addr,      exp_baddr);
            chk("bus_wstrb",   32'(bus_if.data_wstrb), exp_wstrb);
            chk("bus_wdata",   bus_if.data_wdata,     exp_bwd);
            chk("valid_in_req", 32'(out_valid),       32'd0);
            seen_wstrb = 32'(bus_if.data_wstrb);
            seen_wdata = bus_if.data_wdata;
            seen_size  = 32'(bus_if.data_size);
            bus_if.data_addr_ok = (i == adly);
            @(negedge clk);
        end
        bus_if.data_addr_ok = 1'b0;
        bus_if.data_data_ok = 1'b0;
        for (int i = 0; i < ddly; i++) begin
            chk("req_low_wait",  32'(bus_if.data_req), 32'd0);
            chk("valid_in_wait", 32'(out_valid),       32'd0);
            @(negedge clk);
        end
        chk("req_low_dataok", 32'(bus_if.data_req), 32'd0);
        bus_if.data_rdata   = rd;
        bus_if.data_data_ok = 1'b1;
        if (e_ld) exp_out = model_load(e_ldm, int'(e_addr[1:0]), rd, e_rt);
        @(negedge clk);
        bus_if.data_data_ok = 1'b0;
        bus_if.data_rdata   = $urandom;
    endtask

    task automatic check_done(input int stall);
        for (int i = 0; i < stall; i++) begin
            chk("valid_stall",    32'(out_valid), 32'd1);
            chk("data_stall",     out_data,       exp_out);
            chk("dest_stall",     32'(out_dest),  e_dest);
            chk("wen_stall",      32'(out_wen),   exp_owen);
            chk("in_ready_stall", 32'(in_ready),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("valid_done",    32'(out_valid), 32'd1);
        chk("data_done",     out_data,       exp_out);
        chk("dest_done",     32'(out_dest),  e_dest);
        chk("wen_done",      32'(out_wen),   exp_owen);
        chk("in_ready_done", 32'(in_ready),  32'd1);
    endtask

    task automatic run_op(input bit ld, input bit st, input int ldm, input int stm,
                          input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wd,
                          input logic [31:0] rt, input logic [31:0] pass, input int dest,
                          input int adly, input int ddly, input logic [31:0] rd, input int stall);
        set_op(ld, st, ldm, stm, addr, wen, wd, rt, pass, dest);
        @(negedge clk);
        in_valid = 1'b0;
        if (e_mem) serve_bus(adly, ddly, rd, adly > 1);
        check_done(stall);
    endtask

    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("valid_released",    32'(out_valid), 32'd0);
        chk("in_ready_released", 32'(in_ready),  32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 0; in_is_load = 0; in_is_store = 0; in_ld_mode = 0;
        in_st_mode = 0; in_addr = 0; in_wen = 0; in_wdata = 0; in_rt_old = 0;
        in_pass_data = 0; in_dest = 0; out_ready = 0;
        bus_if.data_addr_ok = 0; bus_if.data_rdata = 0; bus_if.data_data_ok = 0;
        repeat (3) @(negedge clk);
        chk("rst_req",   32'(bus_if.data_req), 32'd0);
        chk("rst_valid", 32'(out_valid),       32'd0);
        chk("rst_data",  out_data,             32'd0);
        chk("rst_addr",  bus_if.data_addr,     32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        run_op(0, 1, 0, 0, 32'h0000_1003, 4'b0001, 32'h0000_00AB, 0, 0, 3, 0, 0, 0, 0);
        chk("sb_wstrb", seen_wstrb, 32'h8);
        chk("sb_wdata", seen_wdata, 32'hAB00_0000);
        chk("sb_size",  seen_size,  32'd0);
        chk("sb_out",   out_data,   32'd0);
        release_op();

        run_op(1, 0, 2, 0, 32'h0000_2002, 0, 0, 0, 0, 7, 1, 1, 32'h8001_1234, 1);
        chk("lh_spec", out_data, 32'hFFFF_8001);
        release_op();
        run_op(1, 0, 3, 0, 32'h0000_2002, 0, 0, 0, 0, 8, 0, 2, 32'h8001_1234, 0);
        chk("lhu_spec", out_data, 32'h0000_8001);
        release_op();

        run_op(1, 0, 5, 0, 32'h0000_3001, 0, 0, 32'hAABB_CCDD, 0, 9, 0, 0, 32'h1122_3344, 0);
        chk("lwl_spec", out_data, 32'h3344_CCDD);
        release_op();
        run_op(1, 0, 6, 0, 32'h0000_3001, 0, 0, 32'hAABB_CCDD, 0, 10, 0, 0, 32'h1122_3344, 0);
        chk("lwr_spec", out_data, 32'hAA11_2233);
        release_op();

        // addr_ok held off for five cycles
        run_op(0, 1, 2, 2, 32'h0000_4006, 4'hF, 32'hCAFE_F00D, 0, 0, 11, 5, 0, 0, 0);
        release_op();

        // WB stalls three cycles, then a load is captured in the same cycle the result leaves
        run_op(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 12, 0, 0, 0, 3);
        set_op(1, 0, 4, 0, 32'h0000_5003, 0, 0, 0, 0, 13);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        serve_bus(0, 0, 32'h0BAD_F00D, 0);
        check_done(0);
        chk("chain_lw", out_data, 32'h0BAD_F00D);
        release_op();

        // reset during WAIT, then a stray data_ok
        set_op(1, 0, 4, 0, 32'h0000_6000, 0, 0, 0, 0, 14);
        @(negedge clk);
        in_valid = 1'b0;
        bus_if.data_addr_ok = 1'b1;
        @(negedge clk);
        bus_if.data_addr_ok = 1'b0;
        chk("wait_req_low", 32'(bus_if.data_req), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_req",      32'(bus_if.data_req), 32'd0);
        chk("rstw_valid",    32'(out_valid),       32'd0);
        chk("rstw_in_ready", 32'(in_ready),        32'd1);
        chk("rstw_addr",     bus_if.data_addr,     32'd0);
        bus_if.data_rdata   = 32'h1234_5678;
        bus_if.data_data_ok = 1'b1;
        @(negedge clk);
        bus_if.data_data_ok = 1'b0;
        chk("late_ok_valid", 32'(out_valid),       32'd0);
        chk("late_ok_req",   32'(bus_if.data_req), 32'd0);
        chk("late_ok_data",  out_data,             32'd0);

        for (int n = 0; n < 40; n++) begin
            int kind, ldm, stm;
            logic [3:0] wen;
            kind = $urandom_range(0, 2);
            ldm  = $urandom_range(0, 6);
            stm  = $urandom_range(0, 3);
            wen  = (stm == 0) ? 4'b0001 : (stm == 1) ? 4'b0011 : 4'($urandom);
            run_op(kind == 0, kind == 1, ldm, stm, $urandom, wen, $urandom, $urandom,
                   $urandom, $urandom_range(0, 31), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, $urandom_range(0, 2));
            release_op();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
